gate_bist: RTL and testbench

- Synthesizable built-in self-test controller for a 2-input combinational gate.
- It is the hardware counterpart of our gate testbenches: it drives exhaustive stimulus (a, b) into an external gate, samples its output y, and compares y against a parameterised truth table.
- It accumulates an error count and reports done and pass through a start/done handshake.
- It sits beside any gate in logic_gates/ (and, or, xor, ...) for on-chip or regression self-checking.

---
 rtl/gate_bist.sv | 135 +++++++++++++
 tb/tb_gate_bist.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/gate_bist.sv
// rtl/gate_bist.sv - exhaustive BIST sequencer and checker for a 2-input gate
module gate_bist #(
    parameter logic [3:0] TRUTH_TABLE   = 4'b1000,
    parameter int         SETTLE_CYCLES = 2,
    parameter int         PASSES        = 1,
    parameter int         ERR_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [1:0]       first_err_vec
);

    localparam int SET_W  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES);
    localparam logic [PASS_W-1:0] LAST_PASS   = PASS_W'(PASSES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        vec, vec_nxt;
    logic [SET_W-1:0]  settle_cnt, settle_nxt;
    logic [PASS_W-1:0] pass_cnt, pass_cnt_nxt;
    logic              busy_nxt, done_nxt, pass_nxt;
    logic [ERR_W-1:0]  err_nxt;
    logic              fev_nxt;
    logic [1:0]        fvec_nxt;
    logic              mismatch;

    // Case inequality so an undriven or X output from the gate is a failure.
    assign mismatch = (y !== TRUTH_TABLE[vec]);

    assign a = vec[1];
    assign b = vec[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            vec             <= 2'b00;
            settle_cnt      <= '0;
            pass_cnt        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 2'b00;
        end else begin
            state           <= state_nxt;
            vec             <= vec_nxt;
            settle_cnt      <= settle_nxt;
            pass_cnt        <= pass_cnt_nxt;
            busy            <= busy_nxt;
            done            <= done_nxt;
            pass            <= pass_nxt;
            err_count       <= err_nxt;
            first_err_valid <= fev_nxt;
            first_err_vec   <= fvec_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        vec_nxt      = vec;
        settle_nxt   = settle_cnt;
        pass_cnt_nxt = pass_cnt;
        busy_nxt     = busy;
        done_nxt     = done;
        pass_nxt     = pass;
        err_nxt      = err_count;
        fev_nxt      = first_err_valid;
        fvec_nxt     = first_err_vec;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt    = APPLY;
                    vec_nxt      = 2'b00;
                    settle_nxt   = SETTLE_LOAD;
                    pass_cnt_nxt = '0;
                    busy_nxt     = 1'b1;
                    done_nxt     = 1'b0;
                    pass_nxt     = 1'b0;
                    err_nxt      = '0;
                    fev_nxt      = 1'b0;
                    fvec_nxt     = 2'b00;
                end
            end
            APPLY: begin
                if (settle_cnt != '0) begin
                    settle_nxt = settle_cnt - 1'b1;
                end else begin
                    if (mismatch) begin
                        if (err_count != '1)
                            err_nxt = err_count + 1'b1;
                        if (!first_err_valid) begin
                            fev_nxt  = 1'b1;
                            fvec_nxt = vec;
                        end
                    end
                    if (vec != 2'b11) begin
                        vec_nxt    = vec + 2'b01;
                        settle_nxt = SETTLE_LOAD;
                    end else if (pass_cnt != LAST_PASS) begin
                        vec_nxt      = 2'b00;
                        pass_cnt_nxt = pass_cnt + 1'b1;
                        settle_nxt   = SETTLE_LOAD;
                    end else begin
                        // Final sample folds into pass on the same edge that raises done.
                        state_nxt = DONE;
                        vec_nxt   = 2'b00;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pass_nxt  = !(first_err_valid || mismatch);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gate_bist.sv
// tb/tb_gate_bist.sv - directed table-driven bench for gate_bist
module tb_gate_bist;

    logic       clk = 1'b0;
    logic       reset, start, start2;
    logic       a, b, y, busy, done, pass, fev;
    logic [3:0] err;
    logic [1:0] fvec;
    logic       a2, b2, busy2, done2, pass2, fev2;
    logic       y2;
    logic [1:0] err2, fvec2;
    int         mode;
    int         passed = 0;
    int         total  = 0;

    always #5 clk = ~clk;

    assign y  = (mode == 0) ? (a & b) : (mode == 1) ? 1'b1 : (a | b);
    assign y2 = 1'b1;

    gate_bist dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .y(y),
        .busy(busy), .done(done), .pass(pass), .err_count(err),
        .first_err_valid(fev), .first_err_vec(fvec)
    );

    gate_bist #(.TRUTH_TABLE(4'b1000), .SETTLE_CYCLES(0), .PASSES(3), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .y(y2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_err_valid(fev2), .first_err_vec(fvec2)
    );

    typedef struct {
        int mode;
        int err;
        int fev;
        int fvec;
        int pass;
    } vec_t;

    vec_t tbl[3];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Walks one default-parameter run: 12 busy cycles, each vector held 3 cycles.
    task automatic sweep(input bit do_start, input bit repulse);
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int c = 0; c < 12; c++) begin
            chk("busy_during_run", busy, 1);
            chk("vector_seq", {a, b}, c / 3);
            start = (repulse && (c == 4 || c == 9)) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
        chk("busy_after_run", busy, 0);
        chk("done_after_run", done, 1);
        chk("ab_after_run", {a, b}, 0);
    endtask

    initial begin
        tbl[0] = '{mode: 0, err: 0, fev: 0, fvec: 0, pass: 1};
        tbl[1] = '{mode: 1, err: 3, fev: 1, fvec: 0, pass: 0};
        tbl[2] = '{mode: 2, err: 2, fev: 1, fvec: 1, pass: 0};

        reset = 1'b1; start = 1'b0; start2 = 1'b0; mode = 0;
        tick();
        tick();
        chk("rst_ab", {a, b}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err, 0);
        chk("rst_fev", fev, 0);
        chk("rst_fvec", fvec, 0);
        chk("rst2_busy", busy2, 0);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            mode = tbl[i].mode;
            do_reset();
            sweep(1'b1, 1'b0);
            chk("tbl_pass", pass, tbl[i].pass);
            chk("tbl_err", err, tbl[i].err);
            chk("tbl_fev", fev, tbl[i].fev);
            chk("tbl_fvec", fvec, tbl[i].fvec);
        end

        // start re-pulsed mid-run is ignored; then a restart from DONE clears results
        mode = 1;
        do_reset();
        sweep(1'b1, 1'b1);
        chk("repulse_err", err, 3);
        chk("repulse_pass", pass, 0);
        mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_done", done, 0);
        chk("restart_err", err, 0);
        chk("restart_fev", fev, 0);
        chk("restart_pass", pass, 0);
        sweep(1'b0, 1'b0);
        chk("restart_final_pass", pass, 1);

        // reset in the middle of the 10 vector
        begin
            bit found = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int n = 0; n < 20 && !found; n++) begin
                if ({a, b} == 2'b10) found = 1'b1;
                else tick();
            end
            chk("reach_vec10", found, 1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_ab", {a, b}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", err, 0);
        chk("midrst_fev", fev, 0);
        tick();
        chk("midrst_idle", busy, 0);
        sweep(1'b1, 1'b0);
        chk("after_rst_pass", pass, 1);
        chk("after_rst_err", err, 0);

        // PASSES=3, SETTLE_CYCLES=0, ERR_W=2, y stuck at 1
        begin
            int raw = 0;
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            for (int c = 0; c < 12; c++) begin
                chk("p3_busy", busy2, 1);
                chk("p3_vec", {a2, b2}, c % 4);
                chk("p3_err_sat", err2, (c < 3) ? c : 3);
                if (y2 !== ((c % 4) == 3)) raw++;
                tick();
            end
            chk("p3_raw_mismatches", raw, 9);
            chk("p3_busy_end", busy2, 0);
            chk("p3_done", done2, 1);
            chk("p3_pass", pass2, 0);
            chk("p3_err", err2, 3);
            chk("p3_fev", fev2, 1);
            chk("p3_fvec", fvec2, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
